// File: rtl/rx_collector_pkg.sv
// Shared types and helpers for the serial receive collector.
// Word width, channel count and the gray-to-binary decode.
package rx_collector_pkg;

  localparam int NUM_CH = 8;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;
  localparam int BIT_W  = $clog2(WORD_W);

  typedef logic [2:0] ch_idx_t;

  function automatic logic [WORD_W-1:0] gray2bin(
    input logic [WORD_W-1:0] g
  );
    logic [WORD_W-1:0] b;
    b[WORD_W-1] = g[WORD_W-1];
    for (int k = WORD_W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/serial_rx_lane.sv
// One receive lane: deserialiser, fragment detect, holding register.
// Decode selected by RX_GRAY_DECODE_EN (raw gray word when undefined).
module serial_rx_lane
  import rx_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_bit,
  input  logic              data_vld,
  input  logic              grant,
  output logic              hold_valid,
  output logic [WORD_W-1:0] hold_data,
  output logic              ovf_evt,
  output logic              frag_evt
);

  localparam logic [BIT_W-1:0] LAST = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] dec_word;
  logic [BIT_W-1:0]  bitcnt;
  logic              done_q;

`ifdef RX_GRAY_DECODE_EN
  assign dec_word = gray2bin(word_q);
`else
  assign dec_word = word_q;
`endif

  // bitcnt is only nonzero while vld stays high, so low here is a drop
  assign frag_evt = !data_vld && (bitcnt != '0);
  assign ovf_evt  = done_q && hold_valid && !grant;

  // Shift in MSB first; capture finished words for the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      word_q <= '0;
      bitcnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (data_vld) begin
        shreg <= {shreg[WORD_W-2:0], data_bit};
        if (bitcnt == LAST) begin
          bitcnt <= '0;
          word_q <= {shreg[WORD_W-2:0], data_bit};
          done_q <= 1'b1;
        end else begin
          bitcnt <= bitcnt + BIT_W'(1);
        end
      end else if (frag_evt) begin
        shreg  <= '0;
        bitcnt <= '0;
      end
    end
  end

  // Holding register; a word arriving while full and ungranted is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (grant) begin
        hold_valid <= 1'b0;
      end
      if (done_q && (!hold_valid || grant)) begin
        hold_valid <= 1'b1;
        hold_data  <= dec_word;
      end
    end
  end

endmodule

// File: rtl/serial_rx_collector.sv
// Merges NUM_CH serial lanes into one valid/ready word stream.
// Gray decode in the lanes is enabled by RX_GRAY_DECODE_EN.
module serial_rx_collector
  import rx_collector_pkg::*;
(
  input  logic              clk_out16x,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] data_out_ch,
  input  logic [NUM_CH-1:0] data_vld_ch,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic [WORD_W-1:0] rx_data,
  output ch_idx_t           rx_ch,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  word_count,
  output logic              ovf_err,
  output logic              frag_err
);

  logic [NUM_CH-1:0] hold_valid;
  logic [WORD_W-1:0] hold_data [NUM_CH];
  logic [NUM_CH-1:0] ovf_evt;
  logic [NUM_CH-1:0] frag_evt;
  logic [NUM_CH-1:0] grant;
  ch_idx_t           rr_ptr;
  ch_idx_t           scan_idx;
  ch_idx_t           gnt_idx;
  logic              gnt_found;
  logic              load_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    serial_rx_lane u_lane (
      .clk        (clk_out16x),
      .rst_n      (rst_n),
      .data_bit   (data_out_ch[i]),
      .data_vld   (data_vld_ch[i]),
      .grant      (grant[i]),
      .hold_valid (hold_valid[i]),
      .hold_data  (hold_data[i]),
      .ovf_evt    (ovf_evt[i]),
      .frag_evt   (frag_evt[i])
    );
  end

  // Round-robin pick of the first pending lane at or after rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    scan_idx  = rr_ptr;
    grant     = '0;
    load_en   = !rx_valid || rx_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = rr_ptr + ch_idx_t'(k);
      if (!gnt_found && hold_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    if (load_en && gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Output register, held stable while stalled
  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_ch    <= '0;
      rr_ptr   <= '0;
    end else if (load_en) begin
      rx_valid <= gnt_found;
      if (gnt_found) begin
        rx_data <= hold_data[gnt_idx];
        rx_ch   <= gnt_idx;
        rr_ptr  <= gnt_idx + ch_idx_t'(1);
      end
    end
  end

  // Count completed handshakes, wrapping naturally
  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (rx_valid && rx_ready) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err  <= 1'b0;
      frag_err <= 1'b0;
    end else begin
      ovf_err  <= (ovf_err && !err_clr) || (|ovf_evt);
      frag_err <= (frag_err && !err_clr) || (|frag_evt);
    end
  end

endmodule

// File: tb/tb_serial_rx_collector.sv
// Directed bench for serial_rx_collector.
// Expected words follow RX_GRAY_DECODE_EN when it is defined.
module tb_serial_rx_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_out_ch;
  logic [7:0]  data_vld_ch;
  logic        rx_ready;
  logic        err_clr;
  logic [15:0] rx_data;
  logic [2:0]  rx_ch;
  logic        rx_valid;
  logic [15:0] word_count;
  logic        ovf_err;
  logic        frag_err;

  int n_chk = 0;
  int n_bad = 0;
  logic [15:0] tx [8];

  always #5 clk = ~clk;

  serial_rx_collector dut (
    .clk_out16x  (clk),
    .rst_n       (rst_n),
    .data_out_ch (data_out_ch),
    .data_vld_ch (data_vld_ch),
    .rx_ready    (rx_ready),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .rx_ch       (rx_ch),
    .rx_valid    (rx_valid),
    .word_count  (word_count),
    .ovf_err     (ovf_err),
    .frag_err    (frag_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] expw(input logic [15:0] b);
`ifdef RX_GRAY_DECODE_EN
    return b;
`else
    return gray(b);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_vld_ch = '0;
    data_out_ch = '0;
  endtask

  task automatic send_word(input logic [7:0] mask);
    for (int b = 15; b >= 0; b--) begin
      for (int i = 0; i < 8; i++) data_out_ch[i] = tx[i][b];
      data_vld_ch = mask;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    rx_ready = 1'b1;
    err_clr = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) tx[i] = '0;
    tick();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_errs", {ovf_err, frag_err}, 0);
    rst_n = 1'b1;
    tick();

    // single-word decode and latency
    tx[0] = 16'h1B2E;
    send_word(8'h01);
    idle();
    tick();
    chk("lat_t1", rx_valid, 0);
    tick();
    chk("lat_t2", rx_valid, 1);
`ifdef RX_GRAY_DECODE_EN
    chk("dec_data", rx_data, 16'h1234);
`else
    chk("dec_data", rx_data, 16'h1B2E);
`endif
    chk("dec_ch", rx_ch, 0);
    tick();
    chk("dec_pulse", rx_valid, 0);
    chk("dec_count", word_count, 1);

    // arbitration from rr_ptr = 0
    do_reset();
    for (int i = 0; i < 8; i++) tx[i] = gray(16'h0100 + 16'(i));
    send_word(8'hFF);
    idle();
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("arb0_valid", rx_valid, 1);
      chk("arb0_ch", rx_ch, k);
      chk("arb0_data", rx_data, expw(16'h0100 + 16'(k)));
    end
    tick();
    chk("arb0_done", rx_valid, 0);
    chk("arb0_count", word_count, 8);

    // move rr_ptr to 5 by serving channel index 4
    do_reset();
    tx[4] = gray(16'h0042);
    send_word(8'h10);
    idle();
    tick();
    tick();
    chk("arb5_pre", rx_ch, 4);
    tick();
    for (int i = 0; i < 8; i++) tx[i] = gray(16'h0100 + 16'(i));
    send_word(8'hFF);
    idle();
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("arb5_ch", rx_ch, (k + 5) % 8);
      chk("arb5_data", rx_data, expw(16'h0100 + 16'((k + 5) % 8)));
    end

    // backpressure and overflow on channel index 2
    do_reset();
    rx_ready = 1'b0;
    tx[2] = gray(16'h1111);
    send_word(8'h04);
    tx[2] = gray(16'h2222);
    send_word(8'h04);
    idle();
    tick();
    tick();
    chk("bp_valid", rx_valid, 1);
    chk("bp_dataA", rx_data, expw(16'h1111));
    chk("bp_ch", rx_ch, 2);
    chk("bp_noovf", ovf_err, 0);
    tx[2] = gray(16'h3333);
    send_word(8'h04);
    idle();
    tick();
    tick();
    chk("bp_ovf", ovf_err, 1);
    chk("bp_holdA", rx_data, expw(16'h1111));
    rx_ready = 1'b1;
    tick();
    chk("bp_dataB", rx_data, expw(16'h2222));
    chk("bp_validB", rx_valid, 1);
    tick();
    chk("bp_dropC", rx_valid, 0);
    chk("bp_count", word_count, 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", ovf_err, 0);

    // fragment on channel index 1
    do_reset();
    for (int c = 0; c < 7; c++) begin
      data_out_ch = 8'h02;
      data_vld_ch = 8'h02;
      tick();
    end
    idle();
    tick();
    chk("frag_set", frag_err, 1);
    tick();
    tick();
    chk("frag_novld", rx_valid, 0);
    tx[1] = 16'h1B2E;
    send_word(8'h02);
    idle();
    tick();
    tick();
    chk("frag_next", rx_data, expw(16'h1234));
    chk("frag_ch", rx_ch, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("frag_clr", frag_err, 0);

    // clear and set in the same cycle
    for (int c = 0; c < 3; c++) begin
      data_vld_ch = 8'h02;
      tick();
    end
    idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_vs_set", frag_err, 1);

    // counter wrap from 0xFFFE
    do_reset();
    force dut.word_count = 16'hFFFE;
    tick();
    release dut.word_count;
    tx[0] = gray(16'h0001);
    tx[1] = gray(16'h0002);
    send_word(8'h03);
    idle();
    tick();
    tick();
    tick();
    chk("wrap_ffff", word_count, 16'hFFFF);
    tick();
    chk("wrap_zero", word_count, 0);

    // reset in the middle of a word on channel index 3
    do_reset();
    rx_ready = 1'b0;
    tx[0] = gray(16'h00FF);
    send_word(8'h01);
    idle();
    tick();
    tick();
    chk("mid_pre", rx_valid, 1);
    tx[3] = 16'hFFFF;
    for (int c = 0; c < 8; c++) begin
      data_out_ch = 8'h08;
      data_vld_ch = 8'h08;
      tick();
    end
    rst_n = 1'b0;
    #2;
    chk("mid_valid", rx_valid, 0);
    chk("mid_data", rx_data, 0);
    chk("mid_all", {rx_ch, word_count, ovf_err, frag_err}, 0);
    idle();
    tick();
    rst_n = 1'b1;
    rx_ready = 1'b1;
    tick();
    tx[3] = gray(16'h0F0F);
    send_word(8'h08);
    idle();
    tick();
    tick();
    chk("mid_after", rx_data, expw(16'h0F0F));
    chk("mid_ch", rx_ch, 3);
    chk("mid_frag", frag_err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
